// File: rtl/counter_preload_host.sv
// rtl/counter_preload_host.sv - host-side load / turnaround / drive / read-back preload sequencer
// Optional feature macro: COUNTER_PRELOAD_HOST_RETRY_EN (re-run a mismatching attempt up to MAX_RETRY times)
module counter_preload_host #(
   parameter int unsigned LOAD_HIGH    = 2,
   parameter int unsigned TURN_CYCLES  = 1,
   parameter int unsigned DRIVE_CYCLES = 4,
   parameter int unsigned CHECK_DELAY  = 3,
   parameter logic [7:0]  EXP_OFFSET   = 8'd4,
   parameter int unsigned MAX_RETRY    = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   input  logic [7:0] req_data,
   output logic       req_ready,
   output logic       load_o,
   output logic [7:0] bus_out,
   output logic [7:0] bus_oe,
   input  logic [7:0] bus_in,
   output logic       busy,
   output logic       done,
   output logic       rsp_match,
   output logic [7:0] rsp_count,
   output logic [1:0] rsp_tries
);
   localparam int unsigned M1   = (LOAD_HIGH > TURN_CYCLES) ? LOAD_HIGH : TURN_CYCLES;
   localparam int unsigned M2   = (DRIVE_CYCLES > CHECK_DELAY + 1) ? DRIVE_CYCLES : CHECK_DELAY + 1;
   localparam int unsigned M3   = (M1 > M2) ? M1 : M2;
   localparam int unsigned MAXP = (M3 > 2) ? M3 : 2;
   localparam int          CW   = (MAXP <= 2) ? 1 : $clog2(MAXP);

`ifdef COUNTER_PRELOAD_HOST_RETRY_EN
   localparam bit RETRY = 1'b1;
`else
   localparam bit RETRY = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE, S_ASSERT, S_TURN, S_DRIVE, S_CHECK, S_COOL
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n, lim;
   logic [7:0]    data;
   logic [7:0]    target;
   logic [1:0]    tries, tries_n;
   logic          again, again_n;
   logic          last, hit, accept, sample;

   assign target = data + EXP_OFFSET;
   assign hit    = (bus_in == target);
   assign last   = (cnt == lim);

   // Terminal count per state; phases compare against N-1 so no wrap is needed.
   always_comb begin
      lim = '0;
      case (state)
         S_ASSERT: lim = CW'(LOAD_HIGH - 1);
         S_TURN:   lim = CW'(TURN_CYCLES - 1);
         S_DRIVE:  lim = CW'(DRIVE_CYCLES - 1);
         S_CHECK:  lim = CW'(CHECK_DELAY);
         S_COOL:   lim = CW'(1);
         default:  lim = '0;
      endcase
   end

   always_comb begin
      state_n = state;
      cnt_n   = last ? '0 : cnt + 1'b1;
      tries_n = tries;
      again_n = again;
      accept  = 1'b0;
      sample  = 1'b0;
      case (state)
         S_IDLE: begin
            if (req_valid) begin
               state_n = S_ASSERT;
               accept  = 1'b1;
               tries_n = 2'd0;
               again_n = 1'b0;
            end
         end
         S_ASSERT: if (last) state_n = S_TURN;
         S_TURN:   if (last) state_n = S_DRIVE;
         S_DRIVE:  if (last) state_n = S_CHECK;
         S_CHECK: begin
            if (last) begin
               state_n = S_COOL;
               if (RETRY && !hit && (tries < 2'(MAX_RETRY))) begin
                  again_n = 1'b1;
               end else begin
                  again_n = 1'b0;
                  sample  = 1'b1;
               end
            end
         end
         S_COOL: begin
            if (last) begin
               state_n = again ? S_ASSERT : S_IDLE;
               if (again) tries_n = tries + 2'd1;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         data      <= 8'h00;
         tries     <= 2'd0;
         again     <= 1'b0;
         req_ready <= 1'b1;
         load_o    <= 1'b0;
         bus_out   <= 8'h00;
         bus_oe    <= 8'h00;
         busy      <= 1'b0;
         done      <= 1'b0;
         rsp_match <= 1'b0;
         rsp_count <= 8'h00;
         rsp_tries <= 2'd0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         tries     <= tries_n;
         again     <= again_n;
         if (accept) data <= req_data;
         req_ready <= (state_n == S_IDLE);
         load_o    <= (state_n == S_ASSERT);
         bus_oe    <= (state_n == S_DRIVE) ? 8'hFF : 8'h00;
         bus_out   <= (state_n == S_DRIVE) ? data : 8'h00;
         busy      <= (state_n != S_IDLE);
         done      <= sample;
         if (sample) begin
            rsp_count <= bus_in;
            rsp_match <= hit;
            rsp_tries <= RETRY ? tries : 2'd0;
         end
      end
   end
endmodule

// File: tb/tb_counter_preload_host.sv
// tb/tb_counter_preload_host.sv - randomized scoreboard bench for counter_preload_host (default build)
module tb_counter_preload_host;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_valid = 1'b0;
   logic [7:0] req_data = 8'h00;
   logic [7:0] bus_in = 8'h00;
   logic       req_ready, load_o, busy, done, rsp_match;
   logic [7:0] bus_out, bus_oe, rsp_count;
   logic [1:0] rsp_tries;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] count;
      logic       match;
   } rsp_t;
   rsp_t exp_q[$];
   rsp_t mon_e;

   counter_preload_host dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .load_o(load_o), .bus_out(bus_out), .bus_oe(bus_oe),
      .bus_in(bus_in), .busy(busy), .done(done), .rsp_match(rsp_match),
      .rsp_count(rsp_count), .rsp_tries(rsp_tries)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual %0h required %0h at %0t", name, act, req, $time);
      end
   endtask

   // Expected read-back verdict: preload plus offset 4, modulo 256.
   function automatic logic [7:0] expect_of(input logic [7:0] d);
      return 8'((int'(d) + 4) % 256);
   endfunction

   // Monitor: bus-safety every cycle, and response scoreboard on each done pulse.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("contention", {31'd0, load_o & (|bus_oe)}, 0);
         chk("oe_legal", {31'd0, (bus_oe == 8'h00) || (bus_oe == 8'hFF)}, 1);
         if (bus_oe == 8'h00) chk("bus_out_idle", bus_out, 8'h00);
         if (done) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL done_unexpected actual done=1 required no pending response at %0t", $time);
            end else begin
               mon_e = exp_q.pop_front();
               chk("rsp_count", rsp_count, mon_e.count);
               chk("rsp_match", rsp_match, mon_e.match);
               chk("rsp_tries", rsp_tries, 2'd0);
            end
         end
      end
   end

   // One transaction from the IDLE cycle; timeline follows phase lengths 2/1/4/4/2 after the accept edge.
   task automatic txn(input logic [7:0] d, input logic [7:0] resp, input bit hold);
      rsp_t e;
      req_valid = 1'b1;
      req_data  = d;
      @(negedge clk);
      chk("req_ready_c0", req_ready, 1);
      chk("busy_c0", busy, 0);
      @(posedge clk);
      e.count = resp;
      e.match = (resp == expect_of(d));
      exp_q.push_back(e);
      for (int k = 1; k <= 13; k++) begin
         #1;
         req_valid = hold;
         req_data  = 8'($urandom);
         bus_in    = (k >= 8 && k <= 11) ? resp : (resp ^ 8'($urandom_range(1, 255)));
         @(negedge clk);
         chk("load_o", load_o, (k >= 1 && k <= 2));
         chk("bus_oe", bus_oe, (k >= 4 && k <= 7) ? 8'hFF : 8'h00);
         chk("bus_out", bus_out, (k >= 4 && k <= 7) ? d : 8'h00);
         chk("done", done, (k == 12));
         chk("busy", busy, 1);
         chk("req_ready", req_ready, 0);
         @(posedge clk);
      end
      #1;
   endtask

   initial begin
      logic [7:0] d;
      logic [7:0] r;
      bit         h;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_load_o", load_o, 0);
      chk("rst_bus_oe", bus_oe, 8'h00);
      chk("rst_bus_out", bus_out, 8'h00);
      chk("rst_done", done, 0);
      chk("rst_rsp_match", rsp_match, 0);
      chk("rst_rsp_count", rsp_count, 8'h00);
      chk("rst_rsp_tries", rsp_tries, 2'd0);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rel_req_ready", req_ready, 1);

      txn(8'h5A, 8'h5E, 1'b0);
      txn(8'hFE, 8'h02, 1'b0);
      txn(8'hFE, 8'h01, 1'b0);
      req_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      txn(8'h10, 8'h14, 1'b1);
      txn(8'h20, 8'h24, 1'b0);

      for (int i = 0; i < 20; i++) begin
         d = 8'($urandom);
         r = ($urandom_range(0, 1) == 1) ? expect_of(d) : 8'($urandom);
         h = ($urandom_range(0, 1) == 1);
         txn(d, r, h);
         if (!h) begin
            req_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
         end
      end
      req_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset in the middle of DRIVE must drop the bus and load immediately.
      req_valid = 1'b1;
      req_data  = 8'h33;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("pre_rst_bus_oe", bus_oe, 8'hFF);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_bus_oe", bus_oe, 8'h00);
      chk("mid_rst_load_o", load_o, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_req_ready", req_ready, 1);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_rsp_count", rsp_count, 8'h00);
      @(posedge clk);
      #1;

      txn(8'h5A, 8'h5E, 1'b0);
      req_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
